branch_predictor_table: RTL and testbench
=========================================

# branch_predictor_table

Parametrised branch direction predictor: a table of 2^IDX_BITS saturating counters of configurable width, indexed bimodally by PC or gshare-style by PC XOR global history, selected at run time. It sits beside the fetch stage (lookup port) and is trained from the branch-resolve stage (update port). It also provides a multi-cycle flush sweep and saturating lookup/mispredict statistics.

## Interface
- IDX_BITS, 10: table index width; depth = 2^IDX_BITS.
- CTR_BITS, 2: counter width, 1..4.
- HIST_BITS, 8: global history length, 1..IDX_BITS.
- CTR_INIT, 1: counter value after reset or flush (1 = weakly not-taken for CTR_BITS=2).
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- MODE  in  1  0 = bimodal, 1 = gshare.
- FLUSH  in  1  one-cycle pulse; starts the clear sweep.
- Busy  out  1  high while the sweep runs.
- LookupValid  in  1  lookup request.
- LookupPC  in  32  fetch PC.
- PredValid  out  1  registered response strobe.
- PredTaken  out  1  predicted direction.
- PredIndex  out  IDX_BITS  table index used; returned unchanged on update.
- UpdValid  in  1  resolved-branch update.
- UpdIndex  in  IDX_BITS  index from the matching PredIndex.
- UpdTaken  in  1  actual outcome.
- UpdMispredict  in  1  prediction was wrong.
- LookupCount  out  32  lookups accepted, saturating.
- MispredCount  out  32  updates with UpdMispredict=1, saturating.

## Operation
- Index: bimodal uses PC[IDX_BITS+1:2]. Gshare uses the same bits XOR the GHR zero-extended on the MSB side to IDX_BITS.
- Prediction: the MSB of the indexed counter.
- Counter update when UpdValid and not Busy:
  - UpdTaken=1: increment, saturating at 2^CTR_BITS-1.
  - UpdTaken=0: decrement, saturating at 0.
- GHR (HIST_BITS): on every accepted update, GHR <= {GHR[HIST_BITS-2:0], UpdTaken}. History is non-speculative and uses update order only.
- MODE may change at any time. It affects only lookups sampled after the change. There is no implicit flush.
- FSM states:
  - IDLE: FLUSH moves to CLEAR with ptr=0 and Busy=1.
  - CLEAR: writes CTR_INIT to entry ptr each cycle and increments ptr. After entry 2^IDX_BITS-1 is written it returns to IDLE with Busy=0 and GHR=0.
  - FLUSH while in CLEAR is ignored. Statistics are not cleared by the sweep.
- During Busy:
  - Lookups are answered with PredValid=1, PredTaken=0, and the computed PredIndex. LookupCount still increments.
  - Updates are dropped entirely: no counter write, no GHR shift, no MispredCount increment.
- Statistics: LookupCount increments on each LookupValid. MispredCount increments on UpdValid & UpdMispredict when not Busy. Both hold at 32'hFFFFFFFF.

## Timing
- Reset (RESET=0, asynchronous):
  - every counter = CTR_INIT, GHR=0, FSM=IDLE
  - Busy=0, PredValid=0, PredTaken=0, PredIndex=0, LookupCount=0, MispredCount=0
- Lookup latency is 1 cycle. LookupValid sampled at edge N gives PredValid/PredTaken/PredIndex valid after edge N, for one cycle. PredValid=0 in cycles with no lookup; the other outputs hold.
- Lookups are fully pipelined at one per cycle.
- Update and GHR changes take effect at the sampling edge. A lookup in the same cycle uses the old GHR and the old counter value (read-before-write, no bypass).
- Flush takes 2^IDX_BITS cycles. With FLUSH sampled at edge N, Busy is high from after edge N through edge N+2^IDX_BITS.
- RESET asserted mid-sweep aborts the sweep. Everything returns to the reset state immediately.
- A lookup and an update to the same index in the same cycle are both legal. A FLUSH in the same cycle as an update: the update is applied, then the sweep starts.

## Test plan
- **Reset:** after reset, lookup PC=0x100 in bimodal mode -> next cycle PredValid=1, PredTaken=0, PredIndex=0x040; counters read 0.
- **Saturation:** 4 taken updates to idx 0x040 (CTR_BITS=2) -> counter 3 and PredTaken=1. Then 1 not-taken -> counter 2, still PredTaken=1. Then 3 more not-taken -> counter 0. A further not-taken stays at 0.
- **Gshare:** 3 taken updates (any index) leave GHR=0x07. A lookup with PC=0x100 in gshare mode -> PredIndex=0x047. Switching to MODE=0 -> PredIndex=0x040.
- **Same-cycle collision:** idx 0x040 holds 1; update taken and lookup PC=0x100 in the same cycle -> PredTaken=0. A lookup in the next cycle -> PredTaken=1.
- **Flush (IDX_BITS=4):**
  - FLUSH -> Busy high for 16 cycles.
  - An update during Busy leaves GHR, the counter, and MispredCount unchanged.
  - A lookup during Busy returns PredTaken=0.
  - Afterwards all entries = CTR_INIT and GHR=0.
  - A second FLUSH mid-sweep does not extend Busy.
- **Counters and reset abort:**
  - 5 mispredict updates -> MispredCount=5.
  - Preloaded 0xFFFFFFFE LookupCount plus 3 lookups -> 0xFFFFFFFF.
  - RESET pulsed mid-sweep -> Busy=0 and all counts 0 immediately.

Source files
------------

// File: rtl/branch_predictor_table.sv
`timescale 1ns/1ps
// branch_predictor_table: bimodal/gshare saturating-counter direction predictor with flush sweep and statistics
module branch_predictor_table #(
  parameter int IDX_BITS  = 10,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 8,
  parameter int CTR_INIT  = 1
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                MODE,
  input  logic                FLUSH,
  output logic                Busy,
  input  logic                LookupValid,
  input  logic [31:0]         LookupPC,
  output logic                PredValid,
  output logic                PredTaken,
  output logic [IDX_BITS-1:0] PredIndex,
  input  logic                UpdValid,
  input  logic [IDX_BITS-1:0] UpdIndex,
  input  logic                UpdTaken,
  input  logic                UpdMispredict,
  output logic [31:0]         LookupCount,
  output logic [31:0]         MispredCount
);
  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CMAX  = '1;
  localparam logic [CTR_BITS-1:0] CINIT = CTR_BITS'(CTR_INIT);
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [IDX_BITS-1:0] ptr;
  logic [HIST_BITS-1:0] ghr;
  logic [CTR_BITS-1:0] tbl [DEPTH];
  logic [IDX_BITS-1:0] pc_idx, look_idx;
  logic upd_ok;
  logic [CTR_BITS-1:0] upd_cur, upd_nxt;
  // Lookup index selection and saturating next value for the update port
  always_comb begin
    pc_idx   = LookupPC[IDX_BITS+1:2];
    look_idx = MODE ? pc_idx ^ IDX_BITS'(ghr) : pc_idx;
    upd_ok   = UpdValid && !Busy;
    upd_cur  = tbl[UpdIndex];
    upd_nxt  = UpdTaken ? (upd_cur == CMAX ? upd_cur : upd_cur + CTR_BITS'(1))
                        : (upd_cur == '0 ? upd_cur : upd_cur - CTR_BITS'(1));
  end
  // Counter table: sweep writes take the port while busy, otherwise resolved updates train it
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET)
      for (int i = 0; i < DEPTH; i++) tbl[i] <= CINIT;
    else if (state == CLEAR)
      tbl[ptr] <= CINIT;
    else if (upd_ok)
      tbl[UpdIndex] <= upd_nxt;
  // Flush sweep FSM and non-speculative global history
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      ptr   <= '0;
      Busy  <= 1'b0;
      ghr   <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + IDX_BITS'(1);
      if (ptr == '1) begin
        state <= IDLE;
        Busy  <= 1'b0;
        ghr   <= '0;
      end
    end else begin
      if (upd_ok) ghr <= (ghr << 1) | HIST_BITS'(UpdTaken);
      if (FLUSH) begin
        state <= CLEAR;
        ptr   <= '0;
        Busy  <= 1'b1;
      end
    end
  // Registered prediction response and saturating statistics
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      PredValid    <= 1'b0;
      PredTaken    <= 1'b0;
      PredIndex    <= '0;
      LookupCount  <= '0;
      MispredCount <= '0;
    end else begin
      PredValid <= LookupValid;
      if (LookupValid) begin
        PredIndex <= look_idx;
        PredTaken <= !Busy && tbl[look_idx][CTR_BITS-1];
      end
      if (LookupValid && LookupCount != '1) LookupCount <= LookupCount + 32'd1;
      if (upd_ok && UpdMispredict && MispredCount != '1) MispredCount <= MispredCount + 32'd1;
    end
endmodule

// File: tb/tb_branch_predictor_table.sv
`timescale 1ns/1ps
// tb_branch_predictor_table: directed and randomized checks of the predictor against a behavioural model
module tb_branch_predictor_table;
  localparam int IB = 8;
  localparam int CB = 2;
  localparam int HB = 8;
  localparam int INIT = 1;
  localparam int D = 1 << IB;
  localparam int CMAX = (1 << CB) - 1;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  logic CLK = 0, RESET = 0, md = 0, fl = 0, lv = 0, uv = 0, ut = 0, um = 0;
  logic [31:0] pc = 0;
  logic [IB-1:0] ui = 0;
  logic Busy, PredValid, PredTaken;
  logic [IB-1:0] PredIndex;
  logic [31:0] LookupCount, MispredCount;
  int nchk = 0, nerr = 0;
  int mctr [D];
  int mghr, mbusy_left, epi;
  longint mlc, mmc;
  bit epv, ept;
  branch_predictor_table #(.IDX_BITS(IB), .CTR_BITS(CB), .HIST_BITS(HB), .CTR_INIT(INIT)) dut (
    .CLK(CLK), .RESET(RESET), .MODE(md), .FLUSH(fl), .Busy(Busy),
    .LookupValid(lv), .LookupPC(pc), .PredValid(PredValid), .PredTaken(PredTaken), .PredIndex(PredIndex),
    .UpdValid(uv), .UpdIndex(ui), .UpdTaken(ut), .UpdMispredict(um),
    .LookupCount(LookupCount), .MispredCount(MispredCount)
  );
  always #5 CLK = ~CLK;
  task automatic model_reset();
    foreach (mctr[i]) mctr[i] = INIT;
    mghr = 0; mbusy_left = 0; mlc = 0; mmc = 0; epv = 0; ept = 0; epi = 0;
  endtask
  // advance one clock with the current inputs, updating the reference model from the pre-edge state
  task automatic step();
    int idx, v;
    idx = int'((pc >> 2) % D);
    if (md) idx = idx ^ mghr;
    epv = lv;
    if (lv) begin
      epi = idx;
      ept = (mbusy_left == 0) && (mctr[idx] >= (1 << (CB - 1)));
      if (mlc < MAX32) mlc++;
    end
    if (mbusy_left > 0) begin
      mbusy_left--;
      if (mbusy_left == 0) begin
        foreach (mctr[i]) mctr[i] = INIT;
        mghr = 0;
      end
    end else begin
      if (uv) begin
        v = mctr[ui];
        mctr[ui] = ut ? (v < CMAX ? v + 1 : v) : (v > 0 ? v - 1 : 0);
        mghr = (mghr * 2 + int'(ut)) % (1 << HB);
        if (um && mmc < MAX32) mmc++;
      end
      if (fl) mbusy_left = D;
    end
    @(posedge CLK);
    #1;
    lv = 0; uv = 0; fl = 0; um = 0;
  endtask
  task automatic do_reset();
    RESET = 0;
    #1;
    model_reset();
    #2;
    RESET = 1;
  endtask
  task automatic upd(input int idx, input bit t, input bit m);
    uv = 1; ui = IB'(idx); ut = t; um = m;
    step();
  endtask
  task automatic look(input logic [31:0] p);
    lv = 1; pc = p;
    step();
  endtask
  task automatic test_reset();
    RESET = 0;
    #1;
    model_reset();
    nchk++;
    if ({Busy, PredValid, PredTaken, PredIndex, LookupCount, MispredCount} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got busy=%b pv=%b pt=%b pi=%h lc=%h mc=%h, expected all zero",
               Busy, PredValid, PredTaken, PredIndex, LookupCount, MispredCount);
    end
    #2;
    RESET = 1;
    md = 0;
    look(32'h100);
    nchk++;
    if (PredValid !== 1'b1 || PredTaken !== 1'b0 || PredIndex !== 8'h40) begin
      nerr++;
      $display("FAIL reset_lookup: got pv=%b pt=%b pi=%h, expected pv=1 pt=0 pi=40", PredValid, PredTaken, PredIndex);
    end
    look(32'h104);
    nchk++;
    if (PredValid !== 1'b1 || PredIndex !== 8'h41) begin
      nerr++;
      $display("FAIL pipelined_lookup: got pv=%b pi=%h, expected pv=1 pi=41", PredValid, PredIndex);
    end
    step();
    nchk++;
    if (PredValid !== 1'b0 || PredIndex !== 8'h41) begin
      nerr++;
      $display("FAIL idle_hold: got pv=%b pi=%h, expected pv=0 pi=41", PredValid, PredIndex);
    end
  endtask
  task automatic test_saturation();
    bit exp_t [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    int ntk [6] = '{4, 0, 0, 0, 0, 0};
    int nnt [6] = '{0, 1, 3, 1, 0, 0};
    int ntk2 [6] = '{0, 0, 0, 0, 1, 1};
    do_reset();
    md = 0;
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < ntk[s] + ntk2[s]; k++) upd(8'h40, 1, 0);
      for (int k = 0; k < nnt[s]; k++) upd(8'h40, 0, 0);
      look(32'h100);
      nchk++;
      if (PredTaken !== exp_t[s]) begin
        nerr++;
        $display("FAIL saturation_step%0d: got pt=%b, expected pt=%b", s, PredTaken, exp_t[s]);
      end
    end
  endtask
  task automatic test_gshare();
    do_reset();
    for (int k = 0; k < 3; k++) upd(8'h13, 1, 0);
    md = 1;
    look(32'h100);
    nchk++;
    if (PredIndex !== 8'h47) begin
      nerr++;
      $display("FAIL gshare_index: got pi=%h, expected 47", PredIndex);
    end
    md = 0;
    look(32'h100);
    nchk++;
    if (PredIndex !== 8'h40) begin
      nerr++;
      $display("FAIL bimodal_after_switch: got pi=%h, expected 40", PredIndex);
    end
  endtask
  task automatic test_collision();
    do_reset();
    md = 0;
    uv = 1; ui = 8'h40; ut = 1; lv = 1; pc = 32'h100;
    step();
    nchk++;
    if (PredTaken !== 1'b0) begin
      nerr++;
      $display("FAIL collision_same_cycle: got pt=%b, expected 0", PredTaken);
    end
    look(32'h100);
    nchk++;
    if (PredTaken !== 1'b1) begin
      nerr++;
      $display("FAIL collision_next_cycle: got pt=%b, expected 1", PredTaken);
    end
  endtask
  task automatic test_flush();
    int cnt;
    do_reset();
    md = 0;
    upd(8'h40, 1, 0);
    upd(8'h40, 1, 0);
    fl = 1;
    step();
    nchk++;
    if (Busy !== 1'b1) begin
      nerr++;
      $display("FAIL flush_busy_start: got busy=%b, expected 1", Busy);
    end
    cnt = 1;
    while (Busy === 1'b1 && cnt < 1000) begin
      if (cnt == 5) begin uv = 1; ui = 8'h40; ut = 1; um = 1; end
      if (cnt == 10) begin lv = 1; pc = 32'h100; end
      if (cnt == 20) fl = 1;
      step();
      if (cnt == 10) begin
        nchk++;
        if (PredValid !== 1'b1 || PredTaken !== 1'b0 || PredIndex !== 8'h40) begin
          nerr++;
          $display("FAIL busy_lookup: got pv=%b pt=%b pi=%h, expected pv=1 pt=0 pi=40", PredValid, PredTaken, PredIndex);
        end
      end
      if (Busy === 1'b1) cnt++;
    end
    nchk++;
    if (cnt != D) begin
      nerr++;
      $display("FAIL flush_length: got %0d busy cycles, expected %0d", cnt, D);
    end
    nchk++;
    if (MispredCount !== 32'd0) begin
      nerr++;
      $display("FAIL busy_update_dropped: got mc=%0d, expected 0", MispredCount);
    end
    md = 1;
    look(32'h100);
    nchk++;
    if (PredIndex !== 8'h40 || PredTaken !== 1'b0) begin
      nerr++;
      $display("FAIL post_flush_ghr: got pi=%h pt=%b, expected pi=40 pt=0", PredIndex, PredTaken);
    end
    md = 0;
    for (int i = 0; i < D; i++) begin
      look(32'(i) << 2);
      nchk++;
      if (PredTaken !== 1'b0 || PredIndex !== IB'(i)) begin
        nerr++;
        $display("FAIL post_flush_entry: got pi=%h pt=%b, expected pi=%h pt=0", PredIndex, PredTaken, IB'(i));
      end
    end
    upd(8'h40, 1, 0);
    look(32'h100);
    nchk++;
    if (PredTaken !== 1'b1) begin
      nerr++;
      $display("FAIL post_flush_init_value: got pt=%b, expected 1", PredTaken);
    end
  endtask
  task automatic test_counters();
    do_reset();
    for (int k = 0; k < 5; k++) upd(k, k[0], 1);
    upd(7, 1, 0);
    nchk++;
    if (MispredCount !== 32'd5) begin
      nerr++;
      $display("FAIL mispredict_count: got %0d, expected 5", MispredCount);
    end
    force dut.LookupCount = 32'hFFFF_FFFE;
    #1;
    release dut.LookupCount;
    mlc = 64'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) look($urandom);
    nchk++;
    if (LookupCount !== 32'hFFFF_FFFF) begin
      nerr++;
      $display("FAIL lookup_saturation: got %h, expected ffffffff", LookupCount);
    end
  endtask
  task automatic test_reset_abort();
    do_reset();
    look(32'h200);
    upd(3, 1, 1);
    fl = 1;
    step();
    for (int k = 0; k < 7; k++) step();
    RESET = 0;
    #1;
    model_reset();
    nchk++;
    if (Busy !== 1'b0 || LookupCount !== 32'd0 || MispredCount !== 32'd0 || PredValid !== 1'b0) begin
      nerr++;
      $display("FAIL reset_abort: got busy=%b lc=%0d mc=%0d pv=%b, expected all 0", Busy, LookupCount, MispredCount, PredValid);
    end
    #2;
    RESET = 1;
    look(32'h100);
    nchk++;
    if (Busy !== 1'b0 || PredTaken !== 1'b0 || PredIndex !== 8'h40) begin
      nerr++;
      $display("FAIL after_abort: got busy=%b pt=%b pi=%h, expected busy=0 pt=0 pi=40", Busy, PredTaken, PredIndex);
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) md = ~md;
      lv = ($urandom_range(0, 3) != 0);
      pc = $urandom;
      uv = $urandom_range(0, 1);
      ui = IB'($urandom);
      ut = $urandom_range(0, 1);
      um = $urandom_range(0, 1);
      fl = ($urandom_range(0, 299) == 0);
      step();
      nchk++;
      if (PredValid !== epv || (epv && (PredTaken !== ept || PredIndex !== IB'(epi)))) begin
        nerr++;
        $display("FAIL random_pred cycle %0d: got pv=%b pt=%b pi=%h, expected pv=%b pt=%b pi=%h",
                 n, PredValid, PredTaken, PredIndex, epv, ept, IB'(epi));
      end
      nchk++;
      if (Busy !== (mbusy_left > 0) || LookupCount !== mlc[31:0] || MispredCount !== mmc[31:0]) begin
        nerr++;
        $display("FAIL random_state cycle %0d: got busy=%b lc=%0d mc=%0d, expected busy=%b lc=%0d mc=%0d",
                 n, Busy, LookupCount, MispredCount, mbusy_left > 0, mlc, mmc);
      end
    end
  endtask
  initial begin
    model_reset();
    #3;
    test_reset();
    test_saturation();
    test_gshare();
    test_collision();
    test_flush();
    test_counters();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
